sdrc_bank_sched: RTL and testbench

Bank scheduler sitting directly downstream of the SDRAM request generator. Accepts page-bounded chunks (bank/row/col/len) over the r2b/b2r handshake. Tracks the open row of each of the 4 banks and emits PRE, ACT and RD/WR command requests, with tRP/tRCD spacing, to the transfer/command stage. Drives b2r_arb_ok so the request generator only takes new application requests when the scheduler can absorb them.

---
 rtl/sdrc_bank_sched.sv | 247 ++++++++++++++++++++++++
 tb/tb_sdrc_bank_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_bank_sched.sv
// sdrc_bank_sched: SDRAM bank scheduler.
// Accepts page-bounded chunks from the request generator, tracks the open
// row of each of the 4 banks and issues PRE/ACT/RD/WR command requests with
// tRP/tRCD spacing to the transfer stage.
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   i_r2b_*                   chunk request (valid, id, flags, bank/row/col/len)
//   o_b2r_ack                 chunk accepted (1-cycle pulse)
//   o_b2r_arb_ok              scheduler idle, new app request may be taken
//   i_cfg_trp_d, i_cfg_trcd_d PRE->ACT and ACT->RD/WR delays in cycles
//   i_x2b_close_all           pulse: all banks have been closed
//   o_b2x_*                   command request and held chunk fields
//   i_x2b_ack                 command accepted
//
// Build option: SDRC_CLOSE_PAGE_EN -- last chunk of a burst carries
// auto-precharge and leaves its bank closed (default: open-page policy).
module sdrc_bank_sched #(
  parameter int unsigned APP_RW       = 9,
  parameter int unsigned SDR_REQ_ID_W = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_r2b_req,
  input  logic [SDR_REQ_ID_W-1:0] i_r2b_req_id,
  input  logic                    i_r2b_start,
  input  logic                    i_r2b_last,
  input  logic                    i_r2b_wrap,
  input  logic                    i_r2b_write,
  input  logic [1:0]              i_r2b_ba,
  input  logic [11:0]             i_r2b_raddr,
  input  logic [11:0]             i_r2b_caddr,
  input  logic [APP_RW-1:0]       i_r2b_len,
  output logic                    o_b2r_ack,
  output logic                    o_b2r_arb_ok,
  input  logic [3:0]              i_cfg_trp_d,
  input  logic [3:0]              i_cfg_trcd_d,
  input  logic                    i_x2b_close_all,
  output logic                    o_b2x_req,
  output logic [1:0]              o_b2x_cmd,
  output logic [1:0]              o_b2x_ba,
  output logic [11:0]             o_b2x_addr,
  output logic [APP_RW-1:0]       o_b2x_len,
  output logic [SDR_REQ_ID_W-1:0] o_b2x_id,
  output logic                    o_b2x_start,
  output logic                    o_b2x_last,
  output logic                    o_b2x_wrap,
  output logic                    o_b2x_auto_pre,
  input  logic                    i_x2b_ack
);

  localparam int unsigned NBANK = 4;
  localparam int unsigned ROW_W = 12;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] CMD_PRE = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;
  localparam logic [1:0] CMD_WR  = 2'b11;

`ifdef SDRC_CLOSE_PAGE_EN
  localparam logic AP_EN = 1'b1;
`else
  localparam logic AP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_XFER
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_close_pend;
  logic [NBANK-1:0]        r_bank_vld;
  logic [ROW_W-1:0]        r_bank_row [NBANK];

  // Holding register for the accepted chunk
  logic [1:0]              r_ba;
  logic [11:0]             r_row;
  logic [11:0]             r_col;
  logic [APP_RW-1:0]       r_len;
  logic [SDR_REQ_ID_W-1:0] r_id;
  logic                    r_start, r_last, r_wrap, r_write;

  // Registered command outputs
  logic                    r_req;
  logic [1:0]              r_cmd;
  logic [11:0]             r_addr;
  logic                    r_auto_pre;

  logic w_idle, w_accept, w_bank_open, w_hit;
  logic [1:0] w_acc_xcmd, w_held_xcmd;

  assign w_idle       = (r_state == S_IDLE);
  assign w_accept     = w_idle & i_r2b_req & ~i_x2b_close_all & ~r_close_pend;
  assign o_b2r_ack    = w_accept;
  assign o_b2r_arb_ok = w_idle & ~r_close_pend & ~i_x2b_close_all;

  assign w_bank_open  = r_bank_vld[i_r2b_ba];
  assign w_hit        = w_bank_open & (r_bank_row[i_r2b_ba] == i_r2b_raddr);
  assign w_acc_xcmd   = i_r2b_write ? CMD_WR : CMD_RD;
  assign w_held_xcmd  = r_write ? CMD_WR : CMD_RD;

  assign o_b2x_req      = r_req;
  assign o_b2x_cmd      = r_cmd;
  assign o_b2x_addr     = r_addr;
  assign o_b2x_auto_pre = r_auto_pre;
  assign o_b2x_ba       = r_ba;
  assign o_b2x_len      = r_len;
  assign o_b2x_id       = r_id;
  assign o_b2x_start    = r_start;
  assign o_b2x_last     = r_last;
  assign o_b2x_wrap     = r_wrap;

  // Scheduler FSM, bank table and command outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_close_pend <= 1'b0;
      r_bank_vld   <= '0;
      for (int i = 0; i < NBANK; i++) r_bank_row[i] <= '0;
      r_ba         <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_len        <= '0;
      r_id         <= '0;
      r_start      <= 1'b0;
      r_last       <= 1'b0;
      r_wrap       <= 1'b0;
      r_write      <= 1'b0;
      r_req        <= 1'b0;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_auto_pre   <= 1'b0;
    end else begin
      // A close-all seen while busy is applied on the next idle cycle
      if (!w_idle && i_x2b_close_all) r_close_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_x2b_close_all || r_close_pend) begin
            r_bank_vld   <= '0;
            r_close_pend <= 1'b0;
          end else if (i_r2b_req) begin
            r_ba    <= i_r2b_ba;
            r_row   <= i_r2b_raddr;
            r_col   <= i_r2b_caddr;
            r_len   <= i_r2b_len;
            r_id    <= i_r2b_req_id;
            r_start <= i_r2b_start;
            r_last  <= i_r2b_last;
            r_wrap  <= i_r2b_wrap;
            r_write <= i_r2b_write;
            r_req   <= 1'b1;
            if (w_hit) begin
              r_state    <= S_XFER;
              r_cmd      <= w_acc_xcmd;
              r_addr     <= i_r2b_caddr;
              r_auto_pre <= AP_EN & i_r2b_last;
            end else if (w_bank_open) begin
              r_state <= S_PRE;
              r_cmd   <= CMD_PRE;
              r_addr  <= '0;
            end else begin
              r_state <= S_ACT;
              r_cmd   <= CMD_ACT;
              r_addr  <= i_r2b_raddr;
            end
          end
        end

        S_PRE: begin
          if (i_x2b_ack) begin
            r_bank_vld[r_ba] <= 1'b0;
            // Delays of 0 or 1 issue the next command right away
            if (i_cfg_trp_d <= CNT_W'(1)) begin
              r_state <= S_ACT;
              r_cmd   <= CMD_ACT;
              r_addr  <= r_row;
            end else begin
              r_state <= S_WAIT_RP;
              r_cnt   <= i_cfg_trp_d - CNT_W'(1);
              r_req   <= 1'b0;
            end
          end
        end

        S_WAIT_RP: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= S_ACT;
            r_req   <= 1'b1;
            r_cmd   <= CMD_ACT;
            r_addr  <= r_row;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_ACT: begin
          if (i_x2b_ack) begin
            r_bank_vld[r_ba] <= 1'b1;
            r_bank_row[r_ba] <= r_row;
            if (i_cfg_trcd_d <= CNT_W'(1)) begin
              r_state    <= S_XFER;
              r_cmd      <= w_held_xcmd;
              r_addr     <= r_col;
              r_auto_pre <= AP_EN & r_last;
            end else begin
              r_state <= S_WAIT_RCD;
              r_cnt   <= i_cfg_trcd_d - CNT_W'(1);
              r_req   <= 1'b0;
            end
          end
        end

        S_WAIT_RCD: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_state    <= S_XFER;
            r_req      <= 1'b1;
            r_cmd      <= w_held_xcmd;
            r_addr     <= r_col;
            r_auto_pre <= AP_EN & r_last;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_XFER: begin
          if (i_x2b_ack) begin
            // Auto-precharge leaves the bank closed
            if (r_auto_pre) r_bank_vld[r_ba] <= 1'b0;
            r_auto_pre <= 1'b0;
            r_req      <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdrc_bank_sched.sv
// Directed self-checking bench for sdrc_bank_sched.
module tb_sdrc_bank_sched;

  localparam logic [1:0] PRE = 2'b00, ACT = 2'b01, RD = 2'b10, WR = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write;
  logic [3:0]  r2b_req_id;
  logic [1:0]  r2b_ba;
  logic [11:0] r2b_raddr, r2b_caddr;
  logic [8:0]  r2b_len;
  logic        b2r_ack, b2r_arb_ok;
  logic [3:0]  cfg_trp_d, cfg_trcd_d;
  logic        x2b_close_all, x2b_ack;
  logic        b2x_req, b2x_start, b2x_last, b2x_wrap, b2x_auto_pre;
  logic [1:0]  b2x_cmd, b2x_ba;
  logic [11:0] b2x_addr;
  logic [8:0]  b2x_len;
  logic [3:0]  b2x_id;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int t_acc, t_ack;

  sdrc_bank_sched #(.APP_RW(9), .SDR_REQ_ID_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_r2b_req(r2b_req), .i_r2b_req_id(r2b_req_id), .i_r2b_start(r2b_start),
    .i_r2b_last(r2b_last), .i_r2b_wrap(r2b_wrap), .i_r2b_write(r2b_write),
    .i_r2b_ba(r2b_ba), .i_r2b_raddr(r2b_raddr), .i_r2b_caddr(r2b_caddr),
    .i_r2b_len(r2b_len), .o_b2r_ack(b2r_ack), .o_b2r_arb_ok(b2r_arb_ok),
    .i_cfg_trp_d(cfg_trp_d), .i_cfg_trcd_d(cfg_trcd_d),
    .i_x2b_close_all(x2b_close_all), .o_b2x_req(b2x_req), .o_b2x_cmd(b2x_cmd),
    .o_b2x_ba(b2x_ba), .o_b2x_addr(b2x_addr), .o_b2x_len(b2x_len),
    .o_b2x_id(b2x_id), .o_b2x_start(b2x_start), .o_b2x_last(b2x_last),
    .o_b2x_wrap(b2x_wrap), .o_b2x_auto_pre(b2x_auto_pre), .i_x2b_ack(x2b_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a chunk and hold it until accepted; returns the accept cycle.
  task automatic send(input logic [1:0] ba, input logic [11:0] row, input logic [11:0] col,
                      input logic [8:0] len, input logic wr, input logic last,
                      input logic [3:0] id, output int t);
    int n = 0;
    r2b_req = 1'b1; r2b_ba = ba; r2b_raddr = row; r2b_caddr = col; r2b_len = len;
    r2b_write = wr; r2b_last = last; r2b_req_id = id; r2b_start = 1'b1; r2b_wrap = 1'b0;
    #1;
    while (!b2r_ack && n < 40) begin tick(); #1; n++; end
    chk("b2r_ack", 32'(b2r_ack), 32'd1);
    t = cyc;
    tick();
    r2b_req = 1'b0;
  endtask

  // Wait for a command, check it and its distance from t_ref, then ack it.
  task automatic expect_cmd(input string tag, input logic [1:0] cmd, input logic [1:0] ba,
                            input logic [11:0] addr, input logic [8:0] len, input logic ap,
                            input int dly, input int t_ref, output int t);
    int n = 0;
    #1;
    while (!b2x_req && n < 40) begin tick(); #1; n++; end
    chk({tag, "_req"}, 32'(b2x_req), 32'd1);
    chk({tag, "_cmd"}, 32'(b2x_cmd), 32'(cmd));
    chk({tag, "_ba"}, 32'(b2x_ba), 32'(ba));
    chk({tag, "_addr"}, 32'(b2x_addr), 32'(addr));
    chk({tag, "_dly"}, 32'(cyc - t_ref), 32'(dly));
    if (cmd[1]) begin
      chk({tag, "_len"}, 32'(b2x_len), 32'(len));
      chk({tag, "_ap"}, 32'(b2x_auto_pre), 32'(ap));
    end
    t = cyc;
    x2b_ack = 1'b1;
    tick();
    x2b_ack = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; r2b_req = 1'b0; r2b_req_id = '0; r2b_start = 1'b0; r2b_last = 1'b0;
    r2b_wrap = 1'b0; r2b_write = 1'b0; r2b_ba = '0; r2b_raddr = '0; r2b_caddr = '0;
    r2b_len = '0; cfg_trp_d = 4'd2; cfg_trcd_d = 4'd3; x2b_close_all = 1'b0; x2b_ack = 1'b0;

    repeat (3) tick();
    chk("rst_req", 32'(b2x_req), 32'd0);
    chk("rst_cmd", 32'(b2x_cmd), 32'd0);
    chk("rst_addr", 32'(b2x_addr), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_arb_ok", 32'(b2r_arb_ok), 32'd1);

    // 1: closed bank -> ACT at T+1, RD at T+4, idle at T+5
    send(2'd1, 12'h123, 12'h010, 9'd8, 1'b0, 1'b0, 4'h5, t_acc);
    expect_cmd("t1_act", ACT, 2'd1, 12'h123, 9'd0, 1'b0, 1, t_acc, t_ack);
    chk("t1_busy_arb", 32'(b2r_arb_ok), 32'd0);
    chk("t1_wait_req", 32'(b2x_req), 32'd0);
    expect_cmd("t1_rd", RD, 2'd1, 12'h010, 9'd8, 1'b0, 3, t_ack, t_ack);
    chk("t1_id", 32'(b2x_id), 32'h5);
    chk("t1_idle_req", 32'(b2x_req), 32'd0);
    chk("t1_idle_arb", 32'(b2r_arb_ok), 32'd1);
    chk("t1_idle_cyc", 32'(cyc - t_acc), 32'd5);

    // 2: page hit -> WR directly
    send(2'd1, 12'h123, 12'h020, 9'd4, 1'b1, 1'b0, 4'h6, t_acc);
    expect_cmd("t2_wr", WR, 2'd1, 12'h020, 9'd4, 1'b0, 1, t_acc, t_ack);

    // 3: page miss -> PRE, ACT +2, RD +3; then a hit on the new row
    send(2'd1, 12'h456, 12'h030, 9'd2, 1'b0, 1'b0, 4'h7, t_acc);
    expect_cmd("t3_pre", PRE, 2'd1, 12'h000, 9'd0, 1'b0, 1, t_acc, t_ack);
    expect_cmd("t3_act", ACT, 2'd1, 12'h456, 9'd0, 1'b0, 2, t_ack, t_ack);
    expect_cmd("t3_rd", RD, 2'd1, 12'h030, 9'd2, 1'b0, 3, t_ack, t_ack);
    send(2'd1, 12'h456, 12'h040, 9'd1, 1'b0, 1'b0, 4'h8, t_acc);
    expect_cmd("t3_hit", RD, 2'd1, 12'h040, 9'd1, 1'b0, 1, t_acc, t_ack);

    // 4: close-all during WAIT_RCD -> extra blocked idle cycle, ba1 needs ACT
    send(2'd2, 12'h111, 12'h000, 9'd1, 1'b0, 1'b0, 4'h1, t_acc);
    expect_cmd("t4_act", ACT, 2'd2, 12'h111, 9'd0, 1'b0, 1, t_acc, t_ack);
    x2b_close_all = 1'b1;
    tick();
    x2b_close_all = 1'b0;
    expect_cmd("t4_rd", RD, 2'd2, 12'h000, 9'd1, 1'b0, 3, t_ack, t_ack);
    chk("t4_pend_arb", 32'(b2r_arb_ok), 32'd0);
    tick();
    chk("t4_free_arb", 32'(b2r_arb_ok), 32'd1);
    send(2'd1, 12'h456, 12'h050, 9'd3, 1'b0, 1'b0, 4'h2, t_acc);
    expect_cmd("t4_reopen", ACT, 2'd1, 12'h456, 9'd0, 1'b0, 1, t_acc, t_ack);
    expect_cmd("t4_rd2", RD, 2'd1, 12'h050, 9'd3, 1'b0, 3, t_ack, t_ack);

    // 5: request and close-all in the same idle cycle
    r2b_req = 1'b1; r2b_ba = 2'd1; r2b_raddr = 12'h456; r2b_caddr = 12'h060;
    x2b_close_all = 1'b1;
    #1;
    chk("t5_no_ack", 32'(b2r_ack), 32'd0);
    chk("t5_no_arb", 32'(b2r_arb_ok), 32'd0);
    tick();
    x2b_close_all = 1'b0;
    send(2'd1, 12'h456, 12'h060, 9'd5, 1'b0, 1'b0, 4'h3, t_acc);
    chk("t5_ack_next", 32'(t_acc > 0), 32'd1);
    expect_cmd("t5_act", ACT, 2'd1, 12'h456, 9'd0, 1'b0, 1, t_acc, t_ack);
    expect_cmd("t5_rd", RD, 2'd1, 12'h060, 9'd5, 1'b0, 3, t_ack, t_ack);

    // cfg delays of 0 behave as 1
    cfg_trp_d = 4'd0; cfg_trcd_d = 4'd0;
    send(2'd1, 12'h789, 12'h070, 9'd6, 1'b1, 1'b0, 4'h4, t_acc);
    expect_cmd("z_pre", PRE, 2'd1, 12'h000, 9'd0, 1'b0, 1, t_acc, t_ack);
    expect_cmd("z_act", ACT, 2'd1, 12'h789, 9'd0, 1'b0, 1, t_ack, t_ack);
    expect_cmd("z_wr", WR, 2'd1, 12'h070, 9'd6, 1'b0, 1, t_ack, t_ack);
    cfg_trp_d = 4'd2; cfg_trcd_d = 4'd3;

    // Last-chunk page policy
    send(2'd0, 12'h200, 12'h008, 9'd2, 1'b0, 1'b1, 4'h9, t_acc);
    expect_cmd("cp_act", ACT, 2'd0, 12'h200, 9'd0, 1'b0, 1, t_acc, t_ack);
`ifdef SDRC_CLOSE_PAGE_EN
    expect_cmd("cp_rd", RD, 2'd0, 12'h008, 9'd2, 1'b1, 3, t_ack, t_ack);
    send(2'd0, 12'h200, 12'h00c, 9'd2, 1'b0, 1'b0, 4'ha, t_acc);
    expect_cmd("cp_reuse", ACT, 2'd0, 12'h200, 9'd0, 1'b0, 1, t_acc, t_ack);
    expect_cmd("cp_rd2", RD, 2'd0, 12'h00c, 9'd2, 1'b0, 3, t_ack, t_ack);
`else
    expect_cmd("cp_rd", RD, 2'd0, 12'h008, 9'd2, 1'b0, 3, t_ack, t_ack);
    send(2'd0, 12'h200, 12'h00c, 9'd2, 1'b0, 1'b0, 4'ha, t_acc);
    expect_cmd("cp_reuse", RD, 2'd0, 12'h00c, 9'd2, 1'b0, 1, t_acc, t_ack);
`endif

    // 6: reset while ACT is pending; table invalidated afterwards
    send(2'd3, 12'h0aa, 12'h001, 9'd7, 1'b1, 1'b0, 4'hb, t_acc);
    #1;
    chk("t6_pend_req", 32'(b2x_req), 32'd1);
    chk("t6_pend_cmd", 32'(b2x_cmd), 32'(ACT));
    reset_n = 1'b0;
    x2b_ack = 1'b1;
    tick();
    x2b_ack = 1'b0;
    chk("t6_rst_req", 32'(b2x_req), 32'd0);
    chk("t6_rst_addr", 32'(b2x_addr), 32'd0);
    chk("t6_rst_ba", 32'(b2x_ba), 32'd0);
    chk("t6_rst_len", 32'(b2x_len), 32'd0);
    chk("t6_rst_id", 32'(b2x_id), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("t6_idle_arb", 32'(b2r_arb_ok), 32'd1);
    send(2'd1, 12'h789, 12'h002, 9'd1, 1'b0, 1'b0, 4'hc, t_acc);
    expect_cmd("t6_reuse", ACT, 2'd1, 12'h789, 9'd0, 1'b0, 1, t_acc, t_ack);
    expect_cmd("t6_rd", RD, 2'd1, 12'h002, 9'd1, 1'b0, 3, t_ack, t_ack);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
